// File: rtl/frame_buffer_pp_if.sv
// Byte-stream, vsync and scanner read bundle for frame_buffer_pp.
// master drives the stream and scanner inputs; slave is the frame store.
interface frame_buffer_pp_if #(
    parameter int ROWS      = 8,
    parameter int ROW_BYTES = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          vsync;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [7:0]    rd_data;
    logic          cmd_valid;
    logic [7:0]    cmd_brightness;
    logic          frame_done;
    logic          frame_swap;
    logic          pkt_err;

    modport master (
        output in_valid, in_data, vsync, rd_row, rd_col,
        input  rd_data, cmd_valid, cmd_brightness,
        input  frame_done, frame_swap, pkt_err
    );

    modport slave (
        input  in_valid, in_data, vsync, rd_row, rd_col,
        output rd_data, cmd_valid, cmd_brightness,
        output frame_done, frame_swap, pkt_err
    );
endinterface

// File: rtl/frame_buffer_pp.sv
// Packet-parsing ping-pong LED frame store; swaps buffers only at vsync.
// Optional mid-packet idle abort: define FB_TIMEOUT_EN.
module frame_buffer_pp #(
    parameter int         ROWS        = 8,
    parameter int         ROW_BYTES   = 8,
    parameter logic [7:0] BRIGHT_RST  = 8'h80,
    parameter int         TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               rst_n,
    frame_buffer_pp_if.slave  bus
);
    localparam int FB = ROWS * ROW_BYTES;
    localparam int AW = $clog2(2 * FB);
    localparam int WW = (FB > 1) ? $clog2(FB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_TYPE, S_ARG, S_DATA
    } state_t;

    state_t        state;
    logic [WW-1:0] wr_cnt;
    logic          front;
    logic          pending;
    logic [7:0]    rd_q;
    logic          cmd_q;
    logic [7:0]    bright_q;
    logic          done_q;
    logic          swap_q;
    logic          err_q;

    logic [7:0]    mem [2*FB];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_ok;
    logic          mem_we;
    logic          swap_go;

    assign mem_we  = bus.in_valid && (state == S_DATA);
    assign swap_go = pending && bus.vsync && (state != S_DATA);
    assign wr_addr = (front ? AW'(0) : AW'(FB)) + AW'(wr_cnt);
    assign rd_addr = (front ? AW'(FB) : AW'(0))
                   + AW'(bus.rd_row) * AW'(ROW_BYTES)
                   + AW'(bus.rd_col);
    assign rd_ok   = (int'(bus.rd_col) < ROW_BYTES)
                   && (int'(bus.rd_row) < ROWS);

    // Storage is deliberately unreset; only complete frames reach the front.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= 8'h00;
        else        rd_q <= rd_ok ? mem[rd_addr] : 8'h00;
    end

`ifdef FB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;
    logic          idle_hit;

    assign idle_hit = (state != S_IDLE) && !bus.in_valid
                   && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (bus.in_valid || state == S_IDLE || idle_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic idle_hit;
    logic unused_timeout;
    assign idle_hit       = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_cnt   <= '0;
            front    <= 1'b0;
            pending  <= 1'b0;
            cmd_q    <= 1'b0;
            bright_q <= BRIGHT_RST;
            done_q   <= 1'b0;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cmd_q  <= 1'b0;
            done_q <= 1'b0;
            swap_q <= 1'b0;
            err_q  <= 1'b0;
            if (swap_go) begin
                front   <= ~front;
                pending <= 1'b0;
                swap_q  <= 1'b1;
            end
            if (bus.in_valid) begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.in_data == 8'hAA) state <= S_HDR;
                    end
                    S_HDR: begin
                        if (bus.in_data == 8'h55)      state <= S_TYPE;
                        else if (bus.in_data == 8'hAA) state <= S_HDR;
                        else                           state <= S_IDLE;
                    end
                    S_TYPE: begin
                        unique case (1'b1)
                            (bus.in_data == 8'hBC): state <= S_ARG;
                            (bus.in_data == 8'hF0): begin
                                state   <= S_DATA;
                                wr_cnt  <= '0;
                                pending <= 1'b0;
                            end
                            default: begin
                                state <= S_IDLE;
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                    S_ARG: begin
                        bright_q <= bus.in_data;
                        cmd_q    <= 1'b1;
                        state    <= S_IDLE;
                    end
                    S_DATA: begin
                        if (wr_cnt == WW'(FB - 1)) begin
                            wr_cnt  <= '0;
                            done_q  <= 1'b1;
                            pending <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (idle_hit) begin
                state  <= S_IDLE;
                wr_cnt <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus.rd_data        = rd_q;
    assign bus.cmd_valid      = cmd_q;
    assign bus.cmd_brightness = bright_q;
    assign bus.frame_done     = done_q;
    assign bus.frame_swap     = swap_q;
    assign bus.pkt_err        = err_q;
endmodule
